// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_pkg
//  Description : Shared types, constants and IO-window helper for the
//                load/store unit.
//  Revision    : 1.0 - initial release
// ============================================================================
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC0 = 2'd1,
        ACC1 = 2'd2
    } lsu_state_t;

    localparam logic        SIZE_BYTE = 1'b0;
    localparam logic        SIZE_HALF = 1'b1;
    localparam logic [15:0] IO_BASE   = 16'h2000;
    localparam int          IO_SPAN   = 4;
    localparam logic [15:0] IDLE_ADDR = 16'h0000;

    // Unsigned offset compare handles the window at any base without overflow.
    function automatic logic is_io(input logic [15:0] addr,
                                   input logic [15:0] base = IO_BASE);
        logic [15:0] off;
        off = addr - base;
        return (off < 16'(IO_SPAN));
    endfunction

endpackage
`default_nettype wire

// File: rtl/load_store_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : load_store_unit_if
//  Description : Request/response and data-memory signals of the load/store
//                unit. slave = unit side, master = execute stage + memory.
//  Revision    : 1.0 - initial release
// ============================================================================
interface load_store_unit_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic              req_size;
    logic              req_signed;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_err;
    logic              wmem;
    logic [ADDR_W-1:0] DAddress;
    logic [DATA_W-1:0] DataIn;
    logic              memc;
    logic [DATA_W-1:0] DataOut;

    modport slave (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, DataOut,
        output req_ready, resp_valid, resp_rdata, resp_err, wmem, DAddress, DataIn, memc
    );

    modport master (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, DataOut,
        input  req_ready, resp_valid, resp_rdata, resp_err, wmem, DAddress, DataIn, memc
    );
endinterface
`default_nettype wire

// File: rtl/lsu_load_extend.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_load_extend
//  Description : Combinational load-result formatter: split-half assembly,
//                halfword pass-through, byte sign/zero extension.
//  Revision    : 1.0 - initial release
// ============================================================================
module lsu_load_extend
    import lsu_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  wire logic              i_size,
    input  wire logic              i_sgn,
    input  wire logic              i_split,
    input  wire logic [7:0]        i_lo_byte,
    input  wire logic [DATA_W-1:0] i_data_out,
    output logic      [DATA_W-1:0] o_result
);

    always_comb begin
        o_result = '0;
        if (i_split) begin
            o_result = {i_data_out[7:0], i_lo_byte};
        end else if (i_size == SIZE_HALF) begin
            o_result = i_data_out;
        end else if (i_sgn) begin
            o_result = {{8{i_data_out[7]}}, i_data_out[7:0]};
        end else begin
            o_result = {8'h00, i_data_out[7:0]};
        end
    end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module      : load_store_unit
//  Description : Data-memory initiator: aligned accesses, misaligned halfword
//                split into two byte cycles, guarded display window.
//                Optional build macro LSU_ALIGN_TRAP_EN: misaligned halfwords
//                return an error instead of being split.
//  Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int                ADDR_W    = 16,
    parameter int                DATA_W    = 16,
    parameter logic [ADDR_W-1:0] IO_BASE   = lsu_pkg::IO_BASE,
    parameter logic [ADDR_W-1:0] IDLE_ADDR = lsu_pkg::IDLE_ADDR
) (
    input  wire logic         CLK,
    input  wire logic         RESET,
    load_store_unit_if.slave  bus
);

    localparam logic [ADDR_W-1:0] c_addr_one = {{(ADDR_W-1){1'b0}}, 1'b1};

    lsu_state_t        state_q, state_d;
    logic              we_q, we_d;
    logic              size_q, size_d;
    logic              sgn_q, sgn_d;
    logic              split_q, split_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [7:0]        lo_q, lo_d;
    logic              resp_valid_q, resp_valid_d;
    logic              resp_err_q, resp_err_d;
    logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;

    logic              w_accept;
    logic              w_touch_io;
    logic              w_io_load;
    logic              w_misaligned;
    logic              w_reject;
    logic [DATA_W-1:0] w_ext;

    assign w_accept     = bus.req_valid && (state_q == IDLE);
    assign w_touch_io   = is_io(bus.req_addr, IO_BASE) ||
                          ((bus.req_size == SIZE_HALF) && is_io(bus.req_addr + c_addr_one, IO_BASE));
    assign w_io_load    = !bus.req_we && w_touch_io;
    assign w_misaligned = (bus.req_size == SIZE_HALF) && bus.req_addr[0];
`ifdef LSU_ALIGN_TRAP_EN
    assign w_reject     = w_io_load || w_misaligned;
`else
    assign w_reject     = w_io_load;
`endif

    lsu_load_extend #(.DATA_W(DATA_W)) u_load_extend (
        .i_size     (size_q),
        .i_sgn      (sgn_q),
        .i_split    (split_q),
        .i_lo_byte  (lo_q),
        .i_data_out (bus.DataOut),
        .o_result   (w_ext)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q      <= IDLE;
            we_q         <= 1'b0;
            size_q       <= SIZE_BYTE;
            sgn_q        <= 1'b0;
            split_q      <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            lo_q         <= '0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            we_q         <= we_d;
            size_q       <= size_d;
            sgn_q        <= sgn_d;
            split_q      <= split_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            lo_q         <= lo_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        we_d         = we_q;
        size_d       = size_q;
        sgn_d        = sgn_q;
        split_d      = split_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        lo_d         = lo_q;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        resp_rdata_d = '0;
        case (state_q)
            IDLE: begin
                if (w_accept) begin
                    we_d    = bus.req_we;
                    size_d  = bus.req_size;
                    sgn_d   = bus.req_signed;
                    split_d = w_misaligned;
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    if (w_reject) begin
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                    end else begin
                        state_d = ACC0;
                    end
                end
            end
            ACC0: begin
                if (split_q) begin
                    lo_d    = bus.DataOut[7:0];
                    state_d = ACC1;
                end else begin
                    state_d      = IDLE;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = we_q ? '0 : w_ext;
                end
            end
            ACC1: begin
                state_d      = IDLE;
                resp_valid_d = 1'b1;
                resp_rdata_d = we_q ? '0 : w_ext;
            end
            default: state_d = IDLE;
        endcase
    end

    // The memory reacts to any window address match, so idle cycles park the bus.
    always_comb begin
        bus.req_ready  = (state_q == IDLE);
        bus.resp_valid = resp_valid_q;
        bus.resp_err   = resp_err_q;
        bus.resp_rdata = resp_rdata_q;
        bus.wmem       = 1'b0;
        bus.DAddress   = IDLE_ADDR;
        bus.DataIn     = '0;
        bus.memc       = SIZE_BYTE;
        case (state_q)
            ACC0: begin
                bus.wmem     = we_q;
                bus.DAddress = addr_q;
                if (split_q) begin
                    bus.memc   = SIZE_BYTE;
                    bus.DataIn = {8'h00, wdata_q[7:0]};
                end else begin
                    bus.memc   = size_q;
                    bus.DataIn = wdata_q;
                end
            end
            ACC1: begin
                bus.wmem     = we_q;
                bus.DAddress = addr_q + c_addr_one;
                bus.memc     = SIZE_BYTE;
                bus.DataIn   = {8'h00, wdata_q[15:8]};
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
CPU-side initiator for the data-memory port. It accepts one load or store request per handshake from the execute stage and drives the memory's wmem, DAddress, DataIn and memc signals. It samples the memory's combinational DataOut. Misaligned halfword accesses are split into two byte cycles, byte loads are sign- or zero-extended, and the memory-mapped display window is guarded so that a load never clobbers the digit registers.

Parameters:
ADDR_W, 16, address width
DATA_W, 16, data width
IO_BASE, 16'h2000, first address of the 4-byte display window (IO_BASE..IO_BASE+3)
IDLE_ADDR, 16'h0000, address driven on DAddress whenever no access is in progress

Ports:
CLK  in  1  clock; all state changes on rising edge
RESET  in  1  reset; synchronous, active-high
req_valid  in  1  request present
req_ready  out  1  unit can accept a request (high only in IDLE)
req_we  in  1  1=store, 0=load
req_size  in  1  0=byte, 1=halfword
req_signed  in  1  sign-extend byte loads
req_addr  in  16  byte address
req_wdata  in  16  store data (byte stores use [7:0])
resp_valid  out  1  one-cycle pulse: request finished; no backpressure
resp_rdata  out  16  load result, valid with resp_valid; 0 for stores and errors
resp_err  out  1  valid with resp_valid
wmem  out  1  memory write enable
DAddress  out  16  memory address
DataIn  out  16  memory write data
memc  out  1  0=byte access, 1=halfword access
DataOut  in  16  memory read data, combinational from DAddress/memc

Behaviour:
- Reset values: state IDLE; req_ready=1; resp_valid=0; resp_rdata=0; resp_err=0; wmem=0; DAddress=IDLE_ADDR; DataIn=0; memc=0.
- The memory drives its digit outputs on any address match, regardless of wmem. The unit therefore drives IDLE_ADDR with wmem=0 in every cycle that is not ACC0 or ACC1.
- States: IDLE, ACC0, ACC1. A request is accepted on the edge where req_valid and req_ready are both high. The request fields are captured at that edge.
- Classification at accept:
  - A load is an "IO load" if any byte it touches lies in IO_BASE..IO_BASE+3.
  - An IO load gets no memory cycle. State stays IDLE, and on the next edge resp_valid=1, resp_err=1, resp_rdata=0. Latency is 1.
  - Stores into the IO window proceed as normal byte or half cycles.
- Aligned cases (byte, or halfword with addr[0]=0): IDLE→ACC0 for one cycle.
  - In ACC0: DAddress=addr, memc=size, wmem=we, DataIn=wdata.
  - At the ACC0 exit edge: read data is captured, state goes to IDLE, and resp_valid=1 in the following cycle. Latency is 2.
- Misaligned halfword (addr[0]=1): IDLE→ACC0→ACC1→IDLE. Latency is 3.
  - ACC0: DAddress=addr, memc=0, DataIn={8'h00,wdata[7:0]}; a load captures DataOut[7:0] into result[7:0].
  - ACC1: DAddress=addr+1 (mod 2^16, so 0xFFFF wraps to 0x0000), memc=0, DataIn={8'h00,wdata[15:8]}; a load captures DataOut[7:0] into result[15:8].
- Load result:
  - Byte, signed: {{8{b[7]}},b}.
  - Byte, unsigned: {8'h00,b}.
  - Halfword: assembled 16 bits; req_signed is ignored.
- req_ready equals (state==IDLE), so a new request may be accepted in the same cycle that resp_valid is high. Peak throughput is one aligned access per 2 cycles.
- resp_valid is high for exactly one cycle per accepted request. resp_err=0 except in the IO-load case and the trap case below.
- RESET high at any edge, including in ACC0 or ACC1: the next cycle is IDLE with reset values and no resp_valid for the aborted request. A partially written misaligned store is not rolled back.
- RESET has priority over an accept on the same edge.

Optional Feature:
LSU_ALIGN_TRAP_EN.
- Defined: a misaligned halfword request gets no memory cycle. resp_valid=1, resp_err=1, resp_rdata=0 on the next edge (latency 1).
- Undefined: the request is split into two byte cycles as described above.

Decomposition:
- Package lsu_pkg holds:
  - the state enum (IDLE, ACC0, ACC1);
  - SIZE_BYTE=1'b0 and SIZE_HALF=1'b1;
  - IO_BASE, IO_SPAN=4, IDLE_ADDR;
  - a function is_io(addr).
- One natural sub-module, lsu_load_extend: purely combinational byte/half assembly and sign/zero extension, instantiated once.

Test Plan:
1. Half store 0xBEEF @0x0010, then half load @0x0010. Expect one cycle of wmem=1, memc=1, DAddress=0x0010. The load returns resp_rdata=0xBEEF with resp_valid 2 edges after accept.
2. After test 1, byte load @0x0011: with req_signed=1 expect 0xFFBE; with req_signed=0 expect 0x00BE.
3. Half store 0x1234 @0x0021. Expect ACC0 with DAddress=0x0021, DataIn[7:0]=0x34 and ACC1 with DAddress=0x0022, DataIn[7:0]=0x12, memc=0 in both. A half load @0x0021 returns 0x1234 at latency 3; with LSU_ALIGN_TRAP_EN defined it returns resp_err=1 at latency 1 and DAddress stays 0x0000.
4. Byte store 0x01 @0x2002 sets dig3=1. A byte load @0x2000 returns resp_err=1, rdata=0, DAddress stays 0x0000, and dig1 is unchanged.
5. Assert RESET during ACC1 of a misaligned store @0x0031. Expect IDLE the next cycle with req_ready=1, wmem=0, DAddress=0x0000, and no resp_valid.
6. Hold req_valid with two back-to-back aligned loads @0x0010 and @0x0012. Expect the second accepted in the cycle resp_valid for the first is high; responses arrive 2 cycles apart.
